// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per block.
// Read hits return combinationally. Misses and all stores go through a single-outstanding req/ack memory port.
//
// state   | meaning
// S_IDLE  | accept a new CPU access; read hits complete here
// S_FILL  | line fill read outstanding for the latched miss address
// S_WRITE | write-through store outstanding for the latched address/data
module dcache_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int SET_SIZE   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [1:0]            cpu_byte_sel,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [1:0]            mem_byte_sel,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int TAG_W = DATA_WIDTH - SET_SIZE - 2;
  localparam int NSETS = 1 << SET_SIZE;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [NSETS-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag_mem  [NSETS];
  logic [DATA_WIDTH-1:0] r_data_mem [NSETS];
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_bsel;
  logic [31:0]           r_hits;
  logic [31:0]           r_misses;

  logic [SET_SIZE-1:0]   w_index;
  logic [TAG_W-1:0]      w_tag;
  logic [SET_SIZE-1:0]   w_fill_index;
  logic                  w_hit;
  logic                  w_idle_req;
  logic                  w_rd_hit;
  logic                  w_rd_miss;
  logic                  w_store;
  logic                  w_store_hit;
  logic                  w_fill_done;
  logic [DATA_WIDTH-1:0] w_wdata_sh;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_index      = cpu_addr[SET_SIZE+1:2];
  assign w_tag        = cpu_addr[DATA_WIDTH-1:SET_SIZE+2];
  assign w_fill_index = r_addr[SET_SIZE+1:2];
  assign w_hit        = r_valid[w_index] && (r_tag_mem[w_index] == w_tag);
  assign w_idle_req   = (r_state == S_IDLE) && cpu_req;
  assign w_rd_hit     = w_idle_req && !cpu_we && w_hit;
  assign w_rd_miss    = w_idle_req && !cpu_we && !w_hit;
  assign w_store      = w_idle_req && cpu_we;
  assign w_store_hit  = w_store && w_hit;
  assign w_fill_done  = (r_state == S_FILL) && mem_ack;

  // Store data is moved onto its byte lanes once, so memory and the merge share it.
  always_comb begin
    w_wdata_sh = cpu_wdata;
    w_be       = 4'b1111;
    case (cpu_byte_sel)
      2'b10: begin
        w_wdata_sh = {{(DATA_WIDTH-8){1'b0}}, cpu_wdata[7:0]} << {cpu_addr[1:0], 3'b000};
        w_be       = 4'b0001 << cpu_addr[1:0];
      end
      2'b01: begin
        w_wdata_sh = {{(DATA_WIDTH-16){1'b0}}, cpu_wdata[15:0]} << {cpu_addr[1], 4'b0000};
        w_be       = 4'b0011 << {cpu_addr[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_merged = r_data_mem[w_index];
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) w_merged[8*b +: 8] = w_wdata_sh[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_valid  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_bsel   <= '0;
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      r_state <= w_next;
      if (w_rd_hit) r_hits <= r_hits + 32'd1;
      if (w_rd_miss) begin
        r_misses <= r_misses + 32'd1;
        r_addr   <= cpu_addr;
      end
      if (w_store) begin
        r_addr  <= cpu_addr;
        r_wdata <= w_wdata_sh;
        r_bsel  <= cpu_byte_sel;
      end
      if (w_fill_done) r_valid[w_fill_index] <= 1'b1;
    end
  end

  // Tag/data storage is left unreset; validity alone decides a hit.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_fill_done) begin
        r_tag_mem[w_fill_index]  <= r_addr[DATA_WIDTH-1:SET_SIZE+2];
        r_data_mem[w_fill_index] <= mem_rdata;
      end else if (w_store_hit) begin
        r_data_mem[w_index] <= w_merged;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    cpu_stall    = 1'b0;
    cpu_rdata    = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_byte_sel = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            cpu_stall = 1'b1;
            w_next    = S_WRITE;
          end else if (w_hit) begin
            cpu_rdata = r_data_mem[w_index];
          end else begin
            cpu_stall = 1'b1;
            w_next    = S_FILL;
          end
        end
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {r_addr[DATA_WIDTH-1:2], 2'b00};
        if (mem_ack) begin
          cpu_rdata = mem_rdata;
          w_next    = S_IDLE;
        end else begin
          cpu_stall = 1'b1;
        end
      end
      S_WRITE: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr     = r_addr;
        mem_wdata    = r_wdata;
        mem_byte_sel = r_bsel;
        if (mem_ack) w_next = S_IDLE;
        else         cpu_stall = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign hit_count  = r_hits;
  assign miss_count = r_misses;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: inputs change on the falling edge and outputs
// are sampled 1 ns later, so each check sees the combinational response of that cycle.
module tb_dcache_controller;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [1:0]  cpu_byte_sel;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_byte_sel;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  dcache_controller #(.DATA_WIDTH(32), .SET_SIZE(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_byte_sel(cpu_byte_sel),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_sel(mem_byte_sel),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Load that must miss; memory acks ack_after cycles after mem_req rises.
  task automatic load_miss(input logic [31:0] addr, input logic [31:0] data, input int ack_after);
    int stalls;
    stalls = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
    #1;
    chk("miss_t0_stall", {31'd0, cpu_stall}, 32'd1);
    chk("miss_t0_memreq", {31'd0, mem_req}, 32'd0);
    chk("miss_t0_rdata", cpu_rdata, 32'd0);
    if (cpu_stall) stalls++;
    for (int c = 1; c <= ack_after + 1; c++) begin
      @(negedge clk);
      mem_ack   = (c == ack_after + 1);
      mem_rdata = mem_ack ? data : 32'hBAD0_BAD0;
      #1;
      chk("fill_memreq", {31'd0, mem_req}, 32'd1);
      if (c == 1) begin
        chk("fill_addr", mem_addr, {addr[31:2], 2'b00});
        chk("fill_we", {31'd0, mem_we}, 32'd0);
      end
      if (mem_ack) chk("fill_rdata", cpu_rdata, data);
      if (cpu_stall) stalls++;
    end
    chk("miss_stall_cycles", 32'(stalls), 32'(ack_after + 1));
    @(negedge clk);
    cpu_req = 1'b0; mem_ack = 1'b0;
    #1;
    chk("fill_memreq_drop", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic load_hit(input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
    #1;
    chk("hit_stall", {31'd0, cpu_stall}, 32'd0);
    chk("hit_rdata", cpu_rdata, exp);
    chk("hit_memreq", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] bsel,
                       input logic [31:0] exp_wdata, input int ack_after);
    int stalls;
    stalls = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr; cpu_wdata = wdata; cpu_byte_sel = bsel;
    #1;
    chk("st_t0_stall", {31'd0, cpu_stall}, 32'd1);
    chk("st_t0_memreq", {31'd0, mem_req}, 32'd0);
    if (cpu_stall) stalls++;
    for (int c = 1; c <= ack_after + 1; c++) begin
      @(negedge clk);
      mem_ack = (c == ack_after + 1);
      #1;
      chk("st_memreq", {31'd0, mem_req}, 32'd1);
      if (c == 1) begin
        chk("st_we", {31'd0, mem_we}, 32'd1);
        chk("st_addr", mem_addr, addr);
        chk("st_wdata", mem_wdata, exp_wdata);
        chk("st_bsel", {30'd0, mem_byte_sel}, {30'd0, bsel});
      end
      if (cpu_stall) stalls++;
    end
    chk("st_stall_cycles", 32'(stalls), 32'(ack_after + 1));
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0; mem_ack = 1'b0;
    #1;
    chk("st_memreq_drop", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; cpu_byte_sel = 2'b00; mem_rdata = '0; mem_ack = 1'b0;

    @(negedge clk); @(negedge clk); #1;
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_memwe", {31'd0, mem_we}, 32'd0);
    chk("rst_memaddr", mem_addr, 32'd0);
    chk("rst_memwdata", mem_wdata, 32'd0);
    chk("rst_membsel", {30'd0, mem_byte_sel}, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read miss then hit
    load_miss(32'h0000_1004, 32'hDEAD_BEEF, 3);
    chk("misses_1", miss_count, 32'd1);
    load_hit(32'h0000_1004, 32'hDEAD_BEEF);
    chk("hits_1", hit_count, 32'd1);

    // Conflict eviction on index 1
    load_miss(32'h0000_2004, 32'h1111_1111, 1);
    chk("misses_2", miss_count, 32'd2);
    load_hit(32'h0000_2004, 32'h1111_1111);
    load_miss(32'h0000_1004, 32'hDEAD_BEEF, 2);
    chk("misses_3", miss_count, 32'd3);
    load_hit(32'h0000_1006, 32'hDEAD_BEEF);
    chk("hits_3", hit_count, 32'd3);

    // Store hits: byte, halfword, and byte_sel 11 acting as word
    store(32'h0000_1006, 32'h0000_00AA, 2'b10, 32'h00AA_0000, 2);
    load_hit(32'h0000_1004, 32'hDEAA_BEEF);
    store(32'h0000_1006, 32'h0000_1234, 2'b01, 32'h1234_0000, 1);
    load_hit(32'h0000_1004, 32'h1234_BEEF);
    store(32'h0000_1004, 32'hCAFE_F00D, 2'b11, 32'hCAFE_F00D, 0);
    load_hit(32'h0000_1004, 32'hCAFE_F00D);
    store(32'h0000_1005, 32'h0000_0055, 2'b10, 32'h0000_5500, 0);
    load_hit(32'h0000_1004, 32'hCAFE_550D);
    chk("hits_after_stores", hit_count, 32'd7);
    chk("misses_after_stores", miss_count, 32'd3);

    // Store miss does not allocate
    store(32'h0000_3000, 32'h55AA_55AA, 2'b00, 32'h55AA_55AA, 0);
    load_miss(32'h0000_3000, 32'h0102_0304, 1);
    chk("misses_4", miss_count, 32'd4);

    // Stray ack in IDLE is ignored
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    #1;
    chk("idle_ack_memreq", {31'd0, mem_req}, 32'd0);
    chk("idle_ack_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    load_hit(32'h0000_3000, 32'h0102_0304);
    chk("hits_8", hit_count, 32'd8);

    // Reset in FILL, with an ack landing on the reset edge
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_4008;
    #1;
    chk("rf_t0_stall", {31'd0, cpu_stall}, 32'd1);
    @(negedge clk); #1;
    chk("rf_fill_memreq", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b0; cpu_req = 1'b0;
    #1;
    chk("rf_memreq", {31'd0, mem_req}, 32'd0);
    chk("rf_hits", hit_count, 32'd0);
    chk("rf_misses", miss_count, 32'd0);
    chk("rf_stall", {31'd0, cpu_stall}, 32'd0);
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    chk("rf_stray_memreq", {31'd0, mem_req}, 32'd0);
    chk("rf_stray_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("rf_idle_memreq", {31'd0, mem_req}, 32'd0);
    load_miss(32'h0000_4008, 32'h9999_9999, 1);
    chk("rf_misses_1", miss_count, 32'd1);
    load_miss(32'h0000_1004, 32'hDEAD_BEEF, 0);
    chk("rf_misses_2", miss_count, 32'd2);
    load_hit(32'h0000_4008, 32'h9999_9999);
    chk("rf_hits_1", hit_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-through, no-write-allocate data cache controller between the CPU memory stage and main data memory. It owns the `CacheBlock` array: 2^SET_SIZE entries, one word per block. It serves read hits combinationally, sequences line fills on read misses, and forwards every store to memory through a single-outstanding req/ack handshake. It also keeps hit and miss counters for performance analysis.

## Interface
- DATA_WIDTH, 32: CPU and memory word width.
- SET_SIZE, 10: index bits. The array has 2^SET_SIZE `CacheBlock` entries. Tag width is DATA_WIDTH-SET_SIZE-2 (20).

Ports:
- clk  in  1  system clock. The block uses one clock, rising edge only.
- rst_n  in  1  reset, synchronous and active-low.
- cpu_req  in  1  access request. Held stable by the CPU while cpu_stall=1.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  32  byte address. Tag = [31:SET_SIZE+2], index = [SET_SIZE+1:2], offset = [1:0].
- cpu_wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- cpu_byte_sel  in  2  `byte_format` encoding: 00 Word, 01 HalfWord, 10 Byte. 11 is treated as Word.
- cpu_rdata  out  32  load data, full word.
- cpu_stall  out  1  1 = CPU must hold its request.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  memory write.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  lane-aligned write data.
- mem_byte_sel  out  2  byte_format for the write.
- mem_rdata  in  32  fill data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- hit_count  out  32  read hits since reset.
- miss_count  out  32  read misses since reset.

## Operation
- Hit = entry[index].V && entry[index].Tag == addr tag.
- FSM states are IDLE, FILL and WRITE.
- **IDLE, read hit:**
  - cpu_rdata = entry.Cache_Data and cpu_stall=0, both combinational.
  - hit_count increments.
  - State stays IDLE.
- **IDLE, read miss:**
  - cpu_stall=1.
  - Latch the address.
  - miss_count increments.
  - Next state is FILL.
- **IDLE, store:**
  - cpu_stall=1.
  - Latch address, lane-shifted data and byte_sel.
  - If hit, merge the bytes into entry.Cache_Data on this edge: Byte → lane addr[1:0]; HalfWord → lane addr[1]; Word → whole word.
  - A store miss does not allocate.
  - Next state is WRITE.
- **FILL:**
  - Drive mem_req=1, mem_we=0, mem_addr={latched[31:2],2'b00}.
  - On mem_ack: write entry {V=1, Tag, mem_rdata}, set cpu_rdata=mem_rdata and cpu_stall=0 in the same cycle, next state IDLE.
- **WRITE:**
  - Drive mem_req=1, mem_we=1, mem_addr=latched address unmodified, mem_wdata=lane-shifted data, mem_byte_sel=latched.
  - On mem_ack: cpu_stall=0, next state IDLE.
- cpu_stall = (IDLE && cpu_req && !read_hit) || (FILL/WRITE && !mem_ack).
- mem_* outputs come only from latched registers, never from cpu_* inputs.
- cpu_rdata = 0 whenever it is not a read-hit or fill-ack cycle.
- mem_ack outside FILL/WRITE is ignored.
- Counters wrap modulo 2^32. Stores are not counted.
- cpu_addr[1:0] on loads does not affect lookup; sub-word extraction is done downstream.

## Timing
- Reset (rst_n=0 at an edge) gives:
  - state IDLE
  - all V=0
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_byte_sel=0
  - hit_count=0, miss_count=0
  - cpu_stall=0 and cpu_rdata=0 while cpu_req=0
- Reset mid-FILL or mid-WRITE aborts the transaction:
  - mem_req drops after the reset edge.
  - No entry is written.
  - A mem_ack arriving afterwards is ignored.
- Read hit: 0-cycle latency; the CPU advances on the same edge.
- Read miss:
  - Request cycle T0.
  - mem_req is high from T1 through the ack cycle Tk inclusive, and low at Tk+1.
  - Data is returned at Tk.
  - Total stall is k cycles.
- Store: same cycle pattern as a read miss, including on a hit (write-through). The hit merge is visible to a load issued at T0+1 or later.
- Only one memory transaction is outstanding at a time. A new cpu_req is evaluated only in IDLE.

## Test plan
- **Read miss then hit:** after reset, load 0x0000_1004; ack 3 cycles after mem_req rises with 0xDEADBEEF. Expect: stall high for 4 cycles, mem_addr=0x0000_1004, rdata=0xDEADBEEF on the ack cycle, miss_count=1. Reload 0x1004: hit with stall=0 the same cycle, hit_count=1.
- **Conflict eviction:** fill 0x1004, then load 0x2004 (same index, tag 2) with data 0x11111111. Expect: second miss. Reload 0x1004: miss again, miss_count=3.
- **Byte store hit:** line 0x1004=0xDEADBEEF; store Byte to 0x1006 with wdata=0x000000AA. Expect: mem_we=1, mem_addr=0x1006, mem_byte_sel=10, mem_wdata=0x00AA0000. After ack, a load of 0x1004 hits with 0xDEAABEEF.
- **HalfWord store hit:** store to 0x1006 with wdata=0x00001234. Expect: mem_wdata=0x12340000, line becomes 0x1234BEEF.
- **Store miss:** store Word to 0x3000 (cold). Expect: memory write with stall until ack; a following load of 0x3000 misses (no allocate).
- **Reset mid-fill:** rst_n=0 while in FILL. Expect: mem_req=0 next cycle, counters=0, a later stray mem_ack is ignored, and a reload of the address misses.
